// File: rtl/pos_cell_stream_reader.sv
// Per-cell position reader: fetches the particle count from word 0, then
// streams positions 1..N through a credit-controlled fall-through FIFO.
module pos_cell_stream_reader #(
    parameter int DATA_WIDTH   = 96,
    parameter int PARTICLE_NUM = 220,
    parameter int ADDR_WIDTH   = 8,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] cell_count,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic                  mem_rden,
    input  logic [DATA_WIDTH-1:0] mem_q,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH-1:0] out_index,
    output logic                  out_last
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = 1 + ADDR_WIDTH + DATA_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] MAX_CNT = ADDR_WIDTH'(PARTICLE_NUM - 1);
    localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        RD_CNT,
        WAIT_CNT,
        STREAM,
        DRAIN,
        DONE
    } state_t;

    state_t state, state_nx;

    logic                  wait_ph, wait_ph_nx;
    logic [ADDR_WIDTH-1:0] next_addr, next_addr_nx;
    logic [ADDR_WIDTH-1:0] count_nx;
    logic [ADDR_WIDTH-1:0] cnt_raw;

    // Read-return pipeline: rv[1] marks that mem_q carries data this cycle
    logic [1:0]            rv;
    logic [ADDR_WIDTH-1:0] tag0, tag1;
    logic                  issue;

    logic [EW-1:0]         fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr, rd_ptr;
    logic [CW-1:0]         occ;
    logic                  fifo_empty;
    logic                  pop, push, fifo_pop;
    logic [CW:0]           load;
    logic [EW-1:0]         ret_entry, head, sel;

    // Output side: fall-through FIFO with a bypass for returning data
    always_comb begin
        fifo_empty = (occ == '0);
        out_valid  = !fifo_empty || rv[1];
        pop        = out_valid && out_ready;
        fifo_pop   = pop && !fifo_empty;
        push       = rv[1] && !(fifo_empty && out_ready);
        ret_entry  = {(tag1 == cell_count), tag1, mem_q};
        head       = fifo_mem[rd_ptr];
        sel        = fifo_empty ? ret_entry : head;
        out_last   = out_valid ? sel[EW-1] : 1'b0;
        out_index  = out_valid ? sel[EW-2 -: ADDR_WIDTH] : '0;
        out_data   = out_valid ? sel[DATA_WIDTH-1:0] : '0;
        load       = (CW+1)'(occ) + (CW+1)'(rv[0]) + (CW+1)'(rv[1])
                   - (CW+1)'(pop);
        cnt_raw    = mem_q[ADDR_WIDTH-1:0];
    end

    // Next-state, read issue and count capture
    always_comb begin
        state_nx     = state;
        wait_ph_nx   = 1'b0;
        next_addr_nx = next_addr;
        count_nx     = cell_count;
        mem_rden     = 1'b0;
        mem_address  = '0;
        issue        = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) state_nx = RD_CNT;
            end
            RD_CNT: begin
                mem_rden = 1'b1;
                state_nx = WAIT_CNT;
            end
            WAIT_CNT: begin
                if (!wait_ph) begin
                    wait_ph_nx = 1'b1;
                end else begin
                    count_nx = (cnt_raw > MAX_CNT) ? MAX_CNT : cnt_raw;
                    next_addr_nx = ADDR_WIDTH'(1);
                    if (count_nx == '0) state_nx = DONE;
                    else state_nx = STREAM;
                end
            end
            STREAM: begin
                if (load < DEPTH_C) begin
                    issue        = 1'b1;
                    mem_rden     = 1'b1;
                    mem_address  = next_addr;
                    next_addr_nx = next_addr + 1'b1;
                    if (next_addr == cell_count) state_nx = DRAIN;
                end
            end
            DRAIN: begin
                if (pop && out_last) state_nx = DONE;
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
        busy = (state == RD_CNT) || (state == WAIT_CNT) ||
               (state == STREAM) || (state == DRAIN);
        done = (state == DONE);
    end

    // Control registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            wait_ph    <= 1'b0;
            next_addr  <= '0;
            cell_count <= '0;
        end else begin
            state      <= state_nx;
            wait_ph    <= wait_ph_nx;
            next_addr  <= next_addr_nx;
            cell_count <= count_nx;
        end
    end

    // Track issued reads and their addresses through the memory latency
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rv   <= 2'b00;
            tag0 <= '0;
            tag1 <= '0;
        end else begin
            rv   <= {rv[0], issue};
            tag0 <= mem_address;
            tag1 <= tag0;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (fifo_pop) rd_ptr <= rd_ptr + 1'b1;
            occ <= occ + CW'(push) - CW'(fifo_pop);
        end
    end

    // FIFO storage, written with the tagged return word
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= ret_entry;
    end

endmodule

// File: tb/tb_pos_cell_stream_reader.sv
// Bench for pos_cell_stream_reader: memory model with 2-cycle latency,
// scoreboard of expected particles, randomized data and backpressure.
module tb_pos_cell_stream_reader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        busy;
    logic        done;
    logic [7:0]  cell_count;
    logic [7:0]  mem_address;
    logic        mem_rden;
    logic [95:0] mem_q;
    logic        out_valid;
    logic        out_ready;
    logic [95:0] out_data;
    logic [7:0]  out_index;
    logic        out_last;

    pos_cell_stream_reader dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .busy        (busy),
        .done        (done),
        .cell_count  (cell_count),
        .mem_address (mem_address),
        .mem_rden    (mem_rden),
        .mem_q       (mem_q),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_index   (out_index),
        .out_last    (out_last)
    );

    always #5 clk = ~clk;

    logic [95:0] mem [256];
    logic [95:0] s1;

    always @(posedge clk) begin
        s1    <= mem_rden ? mem[mem_address]
                          : {$urandom, $urandom, $urandom};
        mem_q <= s1;
    end

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;
    int cyc0   = 0;
    int rdy_mode = 0;
    logic start_req = 1'b0;

    logic [104:0] expq [$];
    int  done_n, done_c, first_v, rd_n, first_addr, last_addr;
    int  issued, acc, last_hs;
    logic busy1;
    logic prev_stall;
    logic [7:0]  hold_idx;
    logic [95:0] hold_data;

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_stats();
        done_n = 0; done_c = -1; first_v = -1; rd_n = 0;
        first_addr = -1; last_addr = -1; issued = 0; acc = 0;
        last_hs = -1; busy1 = 1'b0; prev_stall = 1'b0;
    endtask

    task automatic tick();
        int ph;
        logic [104:0] e;
        @(negedge clk);
        cyc++;
        start = start_req;
        ph = (cyc - cyc0) % 4;
        if (rdy_mode == 0) out_ready = 1'b1;
        else if (rdy_mode == 1) out_ready = (ph == 0) || (ph == 3);
        else out_ready = 1'($urandom_range(0, 1));
        #1;
        if (prev_stall)
            chk("stall_hold", {out_valid, out_index, out_data},
                {1'b1, hold_idx, hold_data});
        if (cyc - cyc0 == 1) busy1 = busy;
        if (out_valid && first_v < 0) first_v = cyc - cyc0;
        if (done) begin
            done_n++;
            done_c = cyc - cyc0;
        end
        if (mem_rden) begin
            rd_n++;
            if (rd_n == 1) first_addr = int'(mem_address);
            last_addr = int'(mem_address);
            if (rd_n > 1) issued++;
        end
        if (out_valid && out_ready) begin
            acc++;
            last_hs = int'(out_index);
            if (expq.size() == 0) begin
                chk("extra_word", 1, 0);
            end else begin
                e = expq.pop_front();
                chk("word", {out_last, out_index, out_data}, e);
            end
        end
        if (mem_rden && rd_n > 1)
            chk("credit", 128'(issued - acc <= 4), 1);
        prev_stall = out_valid && !out_ready;
        hold_idx   = out_index;
        hold_data  = out_data;
    endtask

    task automatic run_cell(input int nfield, input int mode,
                            input bit extra, input bit pat,
                            input int abort_at);
        int n, k;
        logic [95:0] w;
        w = {$urandom, $urandom, $urandom};
        w[7:0] = 8'(nfield);
        mem[0] = w;
        for (int a = 1; a < 256; a++)
            mem[a] = pat ? 96'(a) * 96'h010203
                         : {$urandom, $urandom, $urandom};
        n = (nfield > 219) ? 219 : nfield;
        expq.delete();
        for (int a = 1; a <= n; a++)
            expq.push_back({(a == n), 8'(a), mem[a]});
        clear_stats();
        rdy_mode = mode;
        cyc0 = cyc + 1;
        start_req = 1'b1;
        tick();
        start_req = 1'b0;
        k = 0;
        if (abort_at > 0) begin
            while (last_hs != abort_at && k < 200) begin
                tick();
                k++;
            end
            chk("abort_point", last_hs, abort_at);
            @(negedge clk);
            rst = 1'b1;
            #1;
            chk("abort_reset_out",
                {busy, done, cell_count, mem_address, mem_rden,
                 out_valid, out_data, out_index, out_last}, 0);
            tick();
            tick();
            chk("abort_busy", busy, 0);
            rst = 1'b0;
            tick();
            return;
        end
        while (done_n == 0 && k < 3000) begin
            if (extra && (k == 1 || k == 7)) start_req = 1'b1;
            tick();
            start_req = 1'b0;
            k++;
        end
        for (int i = 0; i < 4; i++) tick();
        chk("done_once", done_n, 1);
        chk("all_words", expq.size(), 0);
        chk("cell_count", cell_count, n);
        chk("read_count", rd_n, n + 1);
        chk("first_addr", first_addr, 0);
        chk("busy_c1", busy1, 1);
        chk("idle_after", {busy, out_valid, mem_rden}, 0);
        if (n > 0) chk("last_addr", last_addr, n);
        if (mode == 0) begin
            chk("done_cycle", done_c, (n > 0) ? 6 + n : 4);
            chk("first_valid", first_v, (n > 0) ? 6 : -1);
        end
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        out_ready = 1'b0;
        for (int a = 0; a < 256; a++) mem[a] = '0;
        clear_stats();
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("reset_ctrl", {busy, done, cell_count, mem_address, mem_rden}, 0);
        chk("reset_out", {out_valid, out_data, out_index, out_last}, 0);
        rst = 1'b0;
        tick();
        chk("idle_no_busy", {busy, mem_rden}, 0);

        run_cell(5, 0, 1'b0, 1'b1, 0);
        run_cell(0, 0, 1'b0, 1'b0, 0);
        run_cell(8, 1, 1'b0, 1'b0, 0);
        run_cell(250, 2, 1'b0, 1'b0, 0);
        run_cell(250, 0, 1'b0, 1'b0, 0);
        run_cell(10, 0, 1'b0, 1'b0, 3);
        run_cell(7, 0, 1'b0, 1'b0, 0);
        run_cell(6, 0, 1'b1, 1'b0, 0);
        for (int i = 0; i < 4; i++)
            run_cell(int'($urandom_range(1, 40)), 2, 1'b0, 1'b0, 0);
        run_cell(1, 1, 1'b0, 1'b0, 0);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
